// File: rtl/ctrl_bus_deframer_pkg.sv
// Frame-size constants and state encoding shared by the framer/deframer pair.
// Both ends use these defaults so that they agree on the maximum frame length.
package ctrl_bus_deframer_pkg;

  localparam int DEF_MAX_LEN   = 1024;
  localparam int DEF_LEN_WIDTH = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_bus_deframer_counter.sv
// In-frame sample counter with clear / load-1 / increment controls and an at-MAX_LEN flag.
// Registered count; the flag is combinational from the count. enb stalls the count.
module ctrl_bus_deframer_counter
  import ctrl_bus_deframer_pkg::*;
#(
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int MAX_LEN   = DEF_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enb,
  input  logic                 i_clr,
  input  logic                 i_load1,
  input  logic                 i_inc,
  output logic [LEN_WIDTH-1:0] o_count,
  output logic                 o_at_max
);

  logic [LEN_WIDTH-1:0] r_count;
  logic                 w_at_max;

  assign w_at_max = (r_count == LEN_WIDTH'(MAX_LEN));

  // Increment is gated by the max flag so the count can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (enb) begin
      if (i_clr) begin
        r_count <= '0;
      end else if (i_load1) begin
        r_count <= LEN_WIDTH'(1);
      end else if (i_inc && !w_at_max) begin
        r_count <= r_count + LEN_WIDTH'(1);
      end
    end
  end

  assign o_count  = r_count;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/ctrl_bus_deframer.sv
// Checks start/end/valid framing on a 1-bit sample stream; forwards in-frame samples, reports length and errors.
// All outputs registered, 1-cycle latency; no backpressure, enb=0 freezes every register.
module ctrl_bus_deframer
  import ctrl_bus_deframer_pkg::*;
#(
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int MAX_LEN   = DEF_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enb,
  input  logic                 dataIn,
  input  logic                 ctrlIn_start,
  input  logic                 ctrlIn_end,
  input  logic                 ctrlIn_valid,
  output logic                 dataOut,
  output logic                 validOut,
  output logic                 frameDone,
  output logic [LEN_WIDTH-1:0] lenOut,
  output logic                 errOut,
  output logic                 busy
);

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_data;
  logic                 r_valid;
  logic                 r_done;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_err;

  logic                 w_valid;
  logic                 w_data;
  logic                 w_done;
  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_err;

  logic                 w_cnt_clr;
  logic                 w_cnt_load1;
  logic                 w_cnt_inc;
  logic [LEN_WIDTH-1:0] w_count;
  logic                 w_at_max;

  ctrl_bus_deframer_counter #(
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_LEN   (MAX_LEN)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .enb      (enb),
    .i_clr    (w_cnt_clr),
    .i_load1  (w_cnt_load1),
    .i_inc    (w_cnt_inc),
    .o_count  (w_count),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (enb) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_len       = r_len;
    w_cnt_clr   = 1'b0;
    w_cnt_load1 = 1'b0;
    w_cnt_inc   = 1'b0;

    if (ctrlIn_valid) begin
      case (r_state)
        IDLE: begin
          if (ctrlIn_start) begin
            w_valid = 1'b1;
            if (ctrlIn_end) begin
              w_done    = 1'b1;
              w_len     = LEN_WIDTH'(1);
              w_cnt_clr = 1'b1;
            end else begin
              w_cnt_load1 = 1'b1;
              w_state_nxt = FRAME;
            end
          end else begin
            w_err = 1'b1;
          end
        end

        FRAME: begin
          if (ctrlIn_start) begin
            // Restart: report the aborted frame, then treat this sample as a new first sample.
            w_err   = 1'b1;
            w_valid = 1'b1;
            if (ctrlIn_end) begin
              w_done      = 1'b1;
              w_len       = LEN_WIDTH'(1);
              w_cnt_clr   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_load1 = 1'b1;
            end
          end else if (w_at_max) begin
            w_err       = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_valid = 1'b1;
            if (ctrlIn_end) begin
              w_done      = 1'b1;
              w_len       = w_count + LEN_WIDTH'(1);
              w_cnt_clr   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  assign w_data = w_valid & dataIn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else if (enb) begin
      r_data  <= w_data;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_len   <= w_len;
      r_err   <= w_err;
    end
  end

  assign dataOut   = r_data;
  assign validOut  = r_valid;
  assign frameDone = r_done;
  assign lenOut    = r_len;
  assign errOut    = r_err;
  assign busy      = (r_state == FRAME);

endmodule

// File: tb/tb_ctrl_bus_deframer.sv
// Scoreboard bench: each step queues the expected output set; each test task drains and compares.
module tb_ctrl_bus_deframer;

  localparam int LW = 11;

  typedef struct packed {
    logic          vld;
    logic          dat;
    logic          done;
    logic          err;
    logic          busy;
    logic [LW-1:0] len;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enb = 1'b0;
  logic          dataIn = 1'b0;
  logic          ctrlIn_start = 1'b0;
  logic          ctrlIn_end = 1'b0;
  logic          ctrlIn_valid = 1'b0;
  logic          dataOut;
  logic          validOut;
  logic          frameDone;
  logic [LW-1:0] lenOut;
  logic          errOut;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t exp_q[$];
  obs_t obs_q[$];

  ctrl_bus_deframer #(.LEN_WIDTH(LW), .MAX_LEN(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .enb          (enb),
    .dataIn       (dataIn),
    .ctrlIn_start (ctrlIn_start),
    .ctrlIn_end   (ctrlIn_end),
    .ctrlIn_valid (ctrlIn_valid),
    .dataOut      (dataOut),
    .validOut     (validOut),
    .frameDone    (frameDone),
    .lenOut       (lenOut),
    .errOut       (errOut),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic obs_t ex(input int vld, input int dat, input int done,
                              input int err, input int bsy, input int len);
    obs_t o;
    o.vld  = (vld != 0);
    o.dat  = (dat != 0);
    o.done = (done != 0);
    o.err  = (err != 0);
    o.busy = (bsy != 0);
    o.len  = LW'(len);
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.vld  = validOut;
    o.dat  = dataOut;
    o.done = frameDone;
    o.err  = errOut;
    o.busy = busy;
    o.len  = lenOut;
    return o;
  endfunction

  // Called 1 time unit after a rising edge; samples outputs 1 unit after the next edge.
  task automatic step(input int en, input int v, input int s, input int e, input int d, input obs_t x);
    enb          = (en != 0);
    ctrlIn_valid = (v != 0);
    ctrlIn_start = (s != 0);
    ctrlIn_end   = (e != 0);
    dataIn       = (d != 0);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    obs_q.push_back(cur());
  endtask

  task automatic test_reset();
    obs_t o;
    #3;
    o = cur();
    n_tests++;
    if (o !== ex(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_state got %p want all zero", o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    enb   = 1'b1;
  endtask

  task automatic test_clean_frame();
    logic [7:0] pat;
    obs_t e_v, o_v;
    int idx;
    pat = 8'b01001101;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, (i == 0) ? 1 : 0, (i == 7) ? 1 : 0, pat[i] ? 1 : 0,
           ex(1, pat[i] ? 1 : 0, (i == 7) ? 1 : 0, 0, (i == 7) ? 0 : 1, (i == 7) ? 8 : 0));
    end
    step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 8));
    idx = 0;
    while (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      o_v = obs_q.pop_front();
      n_tests++;
      if (o_v !== e_v) begin
        n_fail++;
        $display("FAIL clean[%0d] got %p want %p", idx, o_v, e_v);
      end
      idx++;
    end
  endtask

  task automatic test_gapped_frame();
    logic [4:0] pat;
    obs_t e_v, o_v;
    int idx;
    pat = 5'b01011;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, (i == 0) ? 1 : 0, (i == 4) ? 1 : 0, pat[i] ? 1 : 0,
           ex(1, pat[i] ? 1 : 0, (i == 4) ? 1 : 0, 0, (i == 4) ? 0 : 1, (i == 4) ? 5 : 8));
      if (i != 4) begin
        step(1, 0, 0, 0, 1, ex(0, 0, 0, 0, 1, 8));
        step(1, 0, 1, 1, 1, ex(0, 0, 0, 0, 1, 8));
      end
    end
    idx = 0;
    while (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      o_v = obs_q.pop_front();
      n_tests++;
      if (o_v !== e_v) begin
        n_fail++;
        $display("FAIL gapped[%0d] got %p want %p", idx, o_v, e_v);
      end
      idx++;
    end
  endtask

  task automatic test_single_sample();
    obs_t e_v, o_v;
    int idx;
    step(1, 1, 1, 1, 1, ex(1, 1, 1, 0, 0, 1));
    step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1));
    idx = 0;
    while (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      o_v = obs_q.pop_front();
      n_tests++;
      if (o_v !== e_v) begin
        n_fail++;
        $display("FAIL single[%0d] got %p want %p", idx, o_v, e_v);
      end
      idx++;
    end
  endtask

  task automatic test_orphan_restart();
    obs_t e_v, o_v;
    int idx;
    step(1, 1, 0, 0, 1, ex(0, 0, 0, 1, 0, 1));
    step(1, 1, 0, 1, 1, ex(0, 0, 0, 1, 0, 1));
    step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1));
    // Restart carrying end: aborted frame and new single-sample frame both reported.
    step(1, 1, 1, 0, 1, ex(1, 1, 0, 0, 1, 1));
    step(1, 1, 0, 0, 0, ex(1, 0, 0, 0, 1, 1));
    step(1, 1, 1, 1, 1, ex(1, 1, 1, 1, 0, 1));
    // Restart after 3 samples, then 2 more with end.
    step(1, 1, 1, 0, 1, ex(1, 1, 0, 0, 1, 1));
    step(1, 1, 0, 0, 0, ex(1, 0, 0, 0, 1, 1));
    step(1, 1, 0, 0, 1, ex(1, 1, 0, 0, 1, 1));
    step(1, 1, 1, 0, 0, ex(1, 0, 0, 1, 1, 1));
    step(1, 1, 0, 0, 1, ex(1, 1, 0, 0, 1, 1));
    step(1, 1, 0, 1, 1, ex(1, 1, 1, 0, 0, 3));
    step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 3));
    idx = 0;
    while (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      o_v = obs_q.pop_front();
      n_tests++;
      if (o_v !== e_v) begin
        n_fail++;
        $display("FAIL orphan_restart[%0d] got %p want %p", idx, o_v, e_v);
      end
      idx++;
    end
  endtask

  task automatic test_overflow();
    obs_t e_v, o_v;
    int idx;
    for (int i = 0; i < 1024; i++) begin
      step(1, 1, (i == 0) ? 1 : 0, 0, i % 2, ex(1, i % 2, 0, 0, 1, 3));
    end
    step(1, 1, 0, 0, 1, ex(0, 0, 0, 1, 0, 3));
    // Back in IDLE: a non-start sample is an orphan.
    step(1, 1, 0, 1, 1, ex(0, 0, 0, 1, 0, 3));
    step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 3));
    idx = 0;
    while (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      o_v = obs_q.pop_front();
      n_tests++;
      if (o_v !== e_v) begin
        n_fail++;
        $display("FAIL overflow[%0d] got %p want %p", idx, o_v, e_v);
      end
      idx++;
    end
  endtask

  task automatic test_enb_stall();
    obs_t e_v, o_v;
    int idx;
    step(1, 1, 1, 0, 1, ex(1, 1, 0, 0, 1, 3));
    step(1, 1, 0, 0, 0, ex(1, 0, 0, 0, 1, 3));
    for (int i = 0; i < 3; i++) begin
      step(0, 1, (i == 1) ? 1 : 0, (i == 2) ? 1 : 0, 1, ex(1, 0, 0, 0, 1, 3));
    end
    step(1, 1, 0, 1, 1, ex(1, 1, 1, 0, 0, 3));
    step(0, 0, 0, 0, 0, ex(1, 1, 1, 0, 0, 3));
    step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 3));
    idx = 0;
    while (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      o_v = obs_q.pop_front();
      n_tests++;
      if (o_v !== e_v) begin
        n_fail++;
        $display("FAIL enb_stall[%0d] got %p want %p", idx, o_v, e_v);
      end
      idx++;
    end
  endtask

  task automatic test_async_reset();
    obs_t e_v, o_v;
    int idx;
    step(1, 1, 1, 0, 1, ex(1, 1, 0, 0, 1, 3));
    step(1, 1, 0, 0, 1, ex(1, 1, 0, 0, 1, 3));
    #2;
    reset = 1'b1;
    #1;
    o_v = cur();
    n_tests++;
    if (o_v !== ex(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL async_reset got %p want all zero", o_v);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    step(1, 1, 0, 1, 1, ex(0, 0, 0, 1, 0, 0));
    step(1, 1, 1, 1, 0, ex(1, 0, 1, 0, 0, 1));
    idx = 0;
    while (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      o_v = obs_q.pop_front();
      n_tests++;
      if (o_v !== e_v) begin
        n_fail++;
        $display("FAIL async_reset_seq[%0d] got %p want %p", idx, o_v, e_v);
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_gapped_frame();
    test_single_sample();
    test_orphan_restart();
    test_overflow();
    test_enb_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
